// File: rtl/control_unit.sv
// Multi-cycle instruction sequencer: fetches 8-bit IRAM words and drives the
// register-enable decoder, bus source select, ALU op, AC load and DRAM strobes.
module control_unit #(
  parameter int PC_W           = 8,
  parameter bit NOP_ON_ILLEGAL = 1'b1
) (
  input  logic            clk,
  input  logic            rstn,
  input  logic            start,
  input  logic [7:0]      instr,
  input  logic            z_flag,
  output logic [PC_W-1:0] iram_addr,
  output logic [3:0]      sel,
  output logic            EN_OP,
  output logic            EN_OUT,
  output logic [3:0]      bus_sel,
  output logic [1:0]      alu_op,
  output logic            ac_ld,
  output logic            dram_rd,
  output logic            dram_wr,
  output logic            done,
  output logic            illegal
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH1,
    S_FETCH2,
    S_DECODE,
    S_EXEC1,
    S_EXEC2,
    S_WB,
    S_HALT
  } state_t;

  localparam logic [3:0] OP_NOP  = 4'h0;
  localparam logic [3:0] OP_LDR  = 4'h1;
  localparam logic [3:0] OP_STR  = 4'h2;
  localparam logic [3:0] OP_MOV  = 4'h3;
  localparam logic [3:0] OP_LDAC = 4'h4;
  localparam logic [3:0] OP_ADD  = 4'h5;
  localparam logic [3:0] OP_SUB  = 4'h6;
  localparam logic [3:0] OP_MUL  = 4'h7;
  localparam logic [3:0] OP_JMP  = 4'h8;
  localparam logic [3:0] OP_JMPZ = 4'h9;
  localparam logic [3:0] OP_END  = 4'hF;

  localparam logic [3:0] BUS_AC   = 4'hD;
  localparam logic [3:0] BUS_DRAM = 4'hE;

  localparam logic [1:0] ALU_PASS = 2'b00;
  localparam logic [1:0] ALU_ADD  = 2'b01;
  localparam logic [1:0] ALU_SUB  = 2'b10;
  localparam logic [1:0] ALU_MUL  = 2'b11;

  localparam logic [PC_W-1:0] PC_ONE = PC_W'(1);

  function automatic logic is_undef(input logic [3:0] op);
    return (op >= 4'hA) && (op <= 4'hE);
  endfunction

  state_t          r_state;
  state_t          w_state_nxt;
  logic [PC_W-1:0] r_pc;
  logic [PC_W-1:0] w_pc_nxt;
  logic [PC_W-1:0] w_target;
  logic [7:0]      r_ir;
  logic [7:0]      w_ir_nxt;
  logic [3:0]      w_op;
  logic [3:0]      w_op_nxt;
  logic [3:0]      w_reg_nxt;

  logic [3:0]      r_sel,     w_sel_nxt;
  logic            r_en_op,   w_en_op_nxt;
  logic            r_en_out,  w_en_out_nxt;
  logic [3:0]      r_bus_sel, w_bus_sel_nxt;
  logic [1:0]      r_alu_op,  w_alu_op_nxt;
  logic            r_ac_ld,   w_ac_ld_nxt;
  logic            r_dram_rd, w_dram_rd_nxt;
  logic            r_dram_wr, w_dram_wr_nxt;
  logic            r_done,    w_done_nxt;
  logic            r_illegal, w_illegal_nxt;

  assign w_op     = r_ir[7:4];
  assign w_target = PC_W'(instr);

  always_comb begin
    w_state_nxt = r_state;
    w_pc_nxt    = r_pc;
    w_ir_nxt    = r_ir;
    case (r_state)
      S_IDLE, S_HALT: begin
        if (start) begin
          w_state_nxt = S_FETCH1;
          w_pc_nxt    = '0;
        end
      end
      S_FETCH1: w_state_nxt = S_FETCH2;
      S_FETCH2: begin
        w_ir_nxt    = instr;
        w_pc_nxt    = r_pc + PC_ONE;
        w_state_nxt = S_DECODE;
      end
      S_DECODE: begin
        if (w_op == OP_NOP)
          w_state_nxt = S_FETCH1;
        else if (w_op == OP_END)
          w_state_nxt = S_HALT;
        else if (is_undef(w_op))
          w_state_nxt = NOP_ON_ILLEGAL ? S_FETCH1 : S_HALT;
        else
          w_state_nxt = S_EXEC1;
      end
      S_EXEC1: begin
        if (w_op == OP_LDR || w_op == OP_JMP || w_op == OP_JMPZ)
          w_state_nxt = S_EXEC2;
        else
          w_state_nxt = S_FETCH1;
      end
      S_EXEC2: begin
        w_state_nxt = S_FETCH1;
        case (w_op)
          OP_LDR:  w_state_nxt = S_WB;
          OP_JMP:  w_pc_nxt = w_target;
          // Not taken: step over the operand byte.
          OP_JMPZ: w_pc_nxt = z_flag ? w_target : (r_pc + PC_ONE);
          default: ;
        endcase
      end
      S_WB:    w_state_nxt = S_FETCH1;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Outputs are decoded from the upcoming state so they leave flops directly.
  assign w_op_nxt  = w_ir_nxt[7:4];
  assign w_reg_nxt = w_ir_nxt[3:0];

  always_comb begin
    w_sel_nxt     = 4'h0;
    w_en_op_nxt   = 1'b0;
    w_en_out_nxt  = 1'b0;
    w_bus_sel_nxt = 4'h0;
    w_alu_op_nxt  = ALU_PASS;
    w_ac_ld_nxt   = 1'b0;
    w_dram_rd_nxt = 1'b0;
    w_dram_wr_nxt = 1'b0;
    w_done_nxt    = 1'b0;
    w_illegal_nxt = 1'b0;
    case (w_state_nxt)
      S_DECODE: w_illegal_nxt = is_undef(w_op_nxt);
      S_EXEC1: begin
        case (w_op_nxt)
          OP_LDAC: begin
            w_bus_sel_nxt = w_reg_nxt;
            w_alu_op_nxt  = ALU_PASS;
            w_ac_ld_nxt   = 1'b1;
          end
          OP_ADD, OP_SUB, OP_MUL: begin
            w_bus_sel_nxt = w_reg_nxt;
            w_ac_ld_nxt   = 1'b1;
            if (w_op_nxt == OP_ADD)
              w_alu_op_nxt = ALU_ADD;
            else if (w_op_nxt == OP_SUB)
              w_alu_op_nxt = ALU_SUB;
            else
              w_alu_op_nxt = ALU_MUL;
          end
          OP_MOV: begin
            w_bus_sel_nxt = BUS_AC;
            w_sel_nxt     = w_reg_nxt;
            w_en_op_nxt   = 1'b1;
            w_en_out_nxt  = 1'b1;
          end
          OP_STR: begin
            w_bus_sel_nxt = w_reg_nxt;
            w_dram_wr_nxt = 1'b1;
          end
          OP_LDR:  w_dram_rd_nxt = 1'b1;
          default: ;
        endcase
      end
      S_WB: begin
        w_bus_sel_nxt = BUS_DRAM;
        w_sel_nxt     = w_reg_nxt;
        w_en_op_nxt   = 1'b1;
        w_en_out_nxt  = 1'b1;
      end
      S_HALT:  w_done_nxt = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      r_state   <= S_IDLE;
      r_pc      <= '0;
      r_ir      <= 8'h00;
      r_sel     <= 4'h0;
      r_en_op   <= 1'b0;
      r_en_out  <= 1'b0;
      r_bus_sel <= 4'h0;
      r_alu_op  <= ALU_PASS;
      r_ac_ld   <= 1'b0;
      r_dram_rd <= 1'b0;
      r_dram_wr <= 1'b0;
      r_done    <= 1'b0;
      r_illegal <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_pc      <= w_pc_nxt;
      r_ir      <= w_ir_nxt;
      r_sel     <= w_sel_nxt;
      r_en_op   <= w_en_op_nxt;
      r_en_out  <= w_en_out_nxt;
      r_bus_sel <= w_bus_sel_nxt;
      r_alu_op  <= w_alu_op_nxt;
      r_ac_ld   <= w_ac_ld_nxt;
      r_dram_rd <= w_dram_rd_nxt;
      r_dram_wr <= w_dram_wr_nxt;
      r_done    <= w_done_nxt;
      r_illegal <= w_illegal_nxt;
    end
  end

  assign iram_addr = r_pc;
  assign sel       = r_sel;
  assign EN_OP     = r_en_op;
  assign EN_OUT    = r_en_out;
  assign bus_sel   = r_bus_sel;
  assign alu_op    = r_alu_op;
  assign ac_ld     = r_ac_ld;
  assign dram_rd   = r_dram_rd;
  assign dram_wr   = r_dram_wr;
  assign done      = r_done;
  assign illegal   = r_illegal;

endmodule

// File: tb/tb_control_unit.sv
// Scoreboard bench for control_unit: directed IRAM programs push expected
// output events; a negedge monitor pops and compares each one the DUT shows.
module tb_control_unit;

  logic       clk = 1'b0;
  logic       rstn, start, z_flag;
  logic [7:0] instr_a, instr_h;
  logic [7:0] addr_a, addr_h;
  logic [3:0] sel_a, bus_a, sel_h, bus_h;
  logic [1:0] alu_a, alu_h;
  logic       en_op_a, en_out_a, ac_a, rd_a, wr_a, done_a, ill_a;
  logic       en_op_h, en_out_h, ac_h, rd_h, wr_h, done_h, ill_h;

  logic [7:0] mem [256];

  always #5 clk = ~clk;

  control_unit #(.PC_W(8), .NOP_ON_ILLEGAL(1'b1)) dut (
    .clk(clk), .rstn(rstn), .start(start), .instr(instr_a), .z_flag(z_flag),
    .iram_addr(addr_a), .sel(sel_a), .EN_OP(en_op_a), .EN_OUT(en_out_a),
    .bus_sel(bus_a), .alu_op(alu_a), .ac_ld(ac_a), .dram_rd(rd_a),
    .dram_wr(wr_a), .done(done_a), .illegal(ill_a)
  );

  control_unit #(.PC_W(8), .NOP_ON_ILLEGAL(1'b0)) dut_h (
    .clk(clk), .rstn(rstn), .start(start), .instr(instr_h), .z_flag(z_flag),
    .iram_addr(addr_h), .sel(sel_h), .EN_OP(en_op_h), .EN_OUT(en_out_h),
    .bus_sel(bus_h), .alu_op(alu_h), .ac_ld(ac_h), .dram_rd(rd_h),
    .dram_wr(wr_h), .done(done_h), .illegal(ill_h)
  );

  // Synchronous-read IRAM: data appears the cycle after the address.
  always @(posedge clk) begin
    instr_a <= mem[addr_a];
    instr_h <= mem[addr_h];
  end

  typedef struct packed {
    logic [7:0] rel;
    logic [7:0] addr;
    logic [3:0] sel;
    logic       en_op;
    logic       en_out;
    logic [3:0] bus;
    logic [1:0] alu;
    logic       ac;
    logic       rd;
    logic       wr;
    logic       ill;
    logic       done;
  } ev_t;

  ev_t q[$];
  int  errors = 0;
  int  checks = 0;
  int  cyc = 0;
  int  c0 = 0;
  bit  mon_en = 1'b0;
  logic done_q = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic int rel();
    return cyc - c0 + 1;
  endfunction

  function automatic ev_t mk(input int r, input int a);
    ev_t e;
    e = '0;
    e.rel  = 8'(r);
    e.addr = 8'(a);
    return e;
  endfunction

  function automatic ev_t ev_alu(input int r, input int a, input logic [3:0] b, input logic [1:0] op);
    ev_t e;
    e = mk(r, a); e.bus = b; e.alu = op; e.ac = 1'b1;
    return e;
  endfunction

  function automatic ev_t ev_reg(input int r, input int a, input logic [3:0] rc, input logic [3:0] b);
    ev_t e;
    e = mk(r, a); e.sel = rc; e.bus = b; e.en_op = 1'b1; e.en_out = 1'b1;
    return e;
  endfunction

  function automatic ev_t ev_rd(input int r, input int a);
    ev_t e;
    e = mk(r, a); e.rd = 1'b1;
    return e;
  endfunction

  function automatic ev_t ev_wr(input int r, input int a, input logic [3:0] b);
    ev_t e;
    e = mk(r, a); e.bus = b; e.wr = 1'b1;
    return e;
  endfunction

  function automatic ev_t ev_ill(input int r, input int a);
    ev_t e;
    e = mk(r, a); e.ill = 1'b1;
    return e;
  endfunction

  function automatic ev_t ev_done(input int r, input int a);
    ev_t e;
    e = mk(r, a); e.done = 1'b1;
    return e;
  endfunction

  always @(negedge clk) begin
    ev_t got;
    ev_t exp;
    if (mon_en) begin
      got = '{rel: 8'(rel()), addr: addr_a, sel: sel_a, en_op: en_op_a, en_out: en_out_a,
              bus: bus_a, alu: alu_a, ac: ac_a, rd: rd_a, wr: wr_a, ill: ill_a,
              done: done_a & ~done_q};
      if (en_op_a || en_out_a || ac_a || rd_a || wr_a || ill_a || (done_a && !done_q) ||
          sel_a != 4'h0 || bus_a != 4'h0 || alu_a != 2'b00) begin
        checks++;
        if (q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_event got=%h (none expected)", got);
        end else begin
          exp = q.pop_front();
          if (got !== exp) begin
            errors++;
            $display("FAIL event got=%h expected=%h", got, exp);
          end
        end
      end
    end
    done_q = done_a;
  end

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h expected=%h", name, got, exp);
    end
  endtask

  task automatic load(input logic [7:0] prog [], input int base);
    for (int i = 0; i < 256; i++) mem[i] = 8'h00;
    for (int i = 0; i < prog.size(); i++) mem[base + i] = prog[i];
  endtask

  task automatic run_prog();
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    #1;
    c0 = cyc;
    start = 1'b0;
    chk("start_addr", 32'(addr_a), 32'h0);
    chk("start_done", 32'(done_a), 32'h0);
  endtask

  task automatic wait_rel(input int n);
    int k;
    k = 0;
    while (rel() != n && k < 200) begin
      @(negedge clk);
      k++;
    end
    if (rel() != n) chk("wait_rel_timeout", 32'(rel()), 32'(n));
  endtask

  task automatic drain();
    int k;
    k = 0;
    while (q.size() != 0 && k < 300) begin
      @(negedge clk);
      k++;
    end
    if (q.size() != 0) begin
      chk("drain_pending", 32'(q.size()), 32'h0);
      q.delete();
    end
    repeat (3) @(negedge clk);
  endtask

  initial begin
    #100000;
    $display("FAIL global_timeout got=%0d cycles expected=finish", cyc);
    $fatal(1, "timeout");
  end

  initial begin
    rstn = 1'b0; start = 1'b0; z_flag = 1'b0;
    for (int i = 0; i < 256; i++) mem[i] = 8'h00;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_outputs",
        {addr_a, sel_a, en_op_a, en_out_a, bus_a, alu_a, ac_a, rd_a, wr_a, done_a, ill_a}, 32'h0);
    @(negedge clk);
    rstn = 1'b1;
    mon_en = 1'b1;

    // LDAC r5, ADD r7, MOV r11, END
    load('{8'h45, 8'h57, 8'h3B, 8'hF0}, 0);
    q.push_back(ev_alu(4, 1, 4'h5, 2'b00));
    q.push_back(ev_alu(8, 2, 4'h7, 2'b01));
    q.push_back(ev_reg(12, 3, 4'hB, 4'hD));
    q.push_back(ev_done(16, 4));
    run_prog();
    drain();

    // LDR r12 then END, restarted from HALT
    load('{8'h1C, 8'hF0}, 0);
    q.push_back(ev_rd(4, 1));
    q.push_back(ev_reg(6, 1, 4'hC, 4'hE));
    q.push_back(ev_done(10, 2));
    run_prog();
    drain();

    // JMPZ taken
    load('{8'h90, 8'h05, 8'h44, 8'h00, 8'h00, 8'h46, 8'hF0}, 0);
    z_flag = 1'b1;
    q.push_back(ev_alu(9, 6, 4'h6, 2'b00));
    q.push_back(ev_done(13, 7));
    run_prog();
    drain();

    // JMPZ not taken: continues after the operand byte
    z_flag = 1'b0;
    q.push_back(ev_alu(9, 3, 4'h4, 2'b00));
    q.push_back(ev_alu(19, 6, 4'h6, 2'b00));
    q.push_back(ev_done(23, 7));
    run_prog();
    drain();

    // JMP to 0xFE, whose operand sits at 0xFF, then pc wraps
    load('{8'h80, 8'hFE, 8'h00, 8'hF0}, 0);
    mem[8'hFE] = 8'h80;
    mem[8'hFF] = 8'h03;
    q.push_back(ev_done(14, 4));
    run_prog();
    drain();

    // SUB r4, MUL r5, STR r9, NOP, END
    load('{8'h64, 8'h75, 8'h29, 8'h00, 8'hF0}, 0);
    q.push_back(ev_alu(4, 1, 4'h4, 2'b10));
    q.push_back(ev_alu(8, 2, 4'h5, 2'b11));
    q.push_back(ev_wr(12, 3, 4'h9));
    q.push_back(ev_done(19, 5));
    run_prog();
    drain();

    // Undefined opcode 0xA3: NOP variant continues, halt variant stops
    load('{8'hA3, 8'h45, 8'hF0}, 0);
    q.push_back(ev_ill(3, 1));
    q.push_back(ev_alu(7, 2, 4'h5, 2'b00));
    q.push_back(ev_done(11, 3));
    run_prog();
    wait_rel(3);
    chk("halt_variant_illegal", {30'h0, ill_h, done_h}, 32'h2);
    wait_rel(4);
    chk("halt_variant_done", {30'h0, ill_h, done_h}, 32'h1);
    drain();

    // start pulsed during EXEC1 is ignored
    load('{8'h45, 8'hF0}, 0);
    q.push_back(ev_alu(4, 1, 4'h5, 2'b00));
    q.push_back(ev_done(8, 2));
    run_prog();
    wait_rel(4);
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    drain();

    // Reset during LDR EXEC2
    load('{8'h1C, 8'hF0}, 0);
    q.push_back(ev_rd(4, 1));
    run_prog();
    wait_rel(5);
    rstn = 1'b0;
    @(posedge clk);
    #1;
    chk("reset_mid_ldr",
        {addr_a, sel_a, en_op_a, en_out_a, bus_a, alu_a, ac_a, rd_a, wr_a, done_a, ill_a}, 32'h0);
    @(negedge clk);
    rstn = 1'b1;
    repeat (4) @(negedge clk);
    chk("idle_after_reset", {addr_a, 7'h0, done_a}, 32'h0);
    chk("queue_empty", 32'(q.size()), 32'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
